mac_dot_sequencer: RTL and testbench

// Sequences one shared MultiplyAdd unit to compute a signed dot product sum(a[i]*b[i]), i=0..len-1.

---
 rtl/mac_dot_sequencer.sv | 156 +++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// Drives one shared MultiplyAdd unit through a signed dot product, one element per MAC round trip.
// The running sum returns to the MAC on its C port, and the final sum is presented with a one-cycle res_valid.
module mac_dot_sequencer #(
    parameter int IN_M_WIDTH = 10,
    parameter int ACC_WIDTH  = 21,
    parameter int LEN_WIDTH  = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  in_valid,
    input  logic [IN_M_WIDTH-1:0] in_a,
    input  logic [IN_M_WIDTH-1:0] in_b,
    output logic                  in_ready,
    output logic                  mac_go,
    output logic [IN_M_WIDTH-1:0] mac_a,
    output logic [IN_M_WIDTH-1:0] mac_b,
    output logic [ACC_WIDTH-1:0]  mac_c,
    input  logic                  mac_out_ready,
    input  logic [ACC_WIDTH-1:0]  mac_res,
    output logic [ACC_WIDTH-1:0]  res,
    output logic                  res_valid,
    output logic                  busy,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [IN_M_WIDTH-1:0] mac_a_q, mac_a_d;
    logic [IN_M_WIDTH-1:0] mac_b_q, mac_b_d;
    logic                  mac_go_q, mac_go_d;
    logic [ACC_WIDTH-1:0]  res_q, res_d;
    logic                  res_valid_q, res_valid_d;
    logic                  err_q, err_d;

    // Stream handshake: a pair transfers on any rising clk edge where in_valid && in_ready;
    // in_ready depends only on state and enable, never on in_valid.
    assign in_ready  = enable && (state_q == ST_ISSUE);
    assign mac_go    = mac_go_q && enable;
    assign res_valid = res_valid_q && enable;
    assign err       = err_q && enable;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_c     = acc_q;
    assign res       = res_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        wd_d        = wd_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_d       = res_q;
        // With enable low every register, pulses included, holds its value.
        mac_go_d    = mac_go_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;

        if (enable) begin
            mac_go_d    = 1'b0;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_d   = len;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_ISSUE;
                        end else begin
                            res_d       = '0;
                            res_valid_d = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (in_valid) begin
                        mac_a_d  = in_a;
                        mac_b_d  = in_b;
                        mac_go_d = 1'b1;
                        wd_d     = '0;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wd_d = wd_q + WD_W'(1);
                    if (mac_out_ready) begin
                        acc_d = mac_res;
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                            res_d       = mac_res;
                            res_valid_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            wd_q        <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_go_q    <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            wd_q        <= wd_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_go_q    <= mac_go_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural MultiplyAdd that holds outReady until the next inReady.
module tb_mac_dot_sequencer;

    localparam int IN_W  = 10;
    localparam int ACC_W = 21;
    localparam int LEN_W = 5;
    localparam int TOUT  = 64;
    localparam logic [ACC_W-1:0] EXP1 = ACC_W'(70);
    localparam logic [ACC_W-1:0] EXP2 = ACC_W'(-261120);
    localparam logic [ACC_W-1:0] EXP6 = ACC_W'(24);

    logic             clk;
    logic             reset;
    logic             enable;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [IN_W-1:0]  in_a, in_b;
    logic             in_ready;
    logic             mac_go;
    logic [IN_W-1:0]  mac_a, mac_b;
    logic [ACC_W-1:0] mac_c;
    logic             mac_out_ready;
    logic [ACC_W-1:0] mac_res;
    logic [ACC_W-1:0] res;
    logic             res_valid;
    logic             busy;
    logic             err;
    logic [1:0]       dbg_state;

    mac_dot_sequencer #(
        .IN_M_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .LEN_WIDTH(LEN_W), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .len(len),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mac_go(mac_go), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_out_ready(mac_out_ready), .mac_res(mac_res),
        .res(res), .res_valid(res_valid), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural MultiplyAdd: computes C + A*B, raises outReady Lmac cycles after inReady
    int               lmac = 2;
    bit               mac_drop = 1'b0;
    bit               pend = 1'b0;
    int               cd = 0;
    logic [ACC_W-1:0] pend_val;

    initial begin
        mac_out_ready = 1'b0;
        mac_res       = '0;
    end

    always @(negedge clk) begin
        if (pend) begin
            if (cd == 0) begin
                mac_out_ready = 1'b1;
                mac_res       = pend_val;
                pend          = 1'b0;
            end else begin
                cd--;
            end
        end
        if (mac_go) begin
            mac_out_ready = 1'b0;
            if (!mac_drop) begin
                pend_val = $signed(mac_c) + $signed(mac_a) * $signed(mac_b);
                pend     = 1'b1;
                cd       = lmac - 1;
            end
        end
    end

    // Monitor / scoreboard counters
    int   go_cnt, rv_cnt, err_cnt, go_run_viol, rv_run_viol;
    bit   busy_seen;
    logic prev_go = 1'b0;
    logic prev_rv = 1'b0;
    time  t_rv, t_acc;

    always @(negedge clk) begin
        if (mac_go) go_cnt++;
        if (mac_go && prev_go) go_run_viol++;
        if (res_valid) begin
            rv_cnt++;
            t_rv = $time;
        end
        if (res_valid && prev_rv) rv_run_viol++;
        if (err) err_cnt++;
        if (busy) busy_seen = 1'b1;
        prev_go = mac_go;
        prev_rv = res_valid;
    end

    task automatic clear_mon();
        go_cnt = 0; rv_cnt = 0; err_cnt = 0; go_run_viol = 0; rv_run_viol = 0;
        busy_seen = 1'b0;
    endtask

    // Driver tasks: all run in the phase #1 after a rising edge
    logic [IN_W-1:0] va[8];
    logic [IN_W-1:0] vb[8];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        tick(1);
        start = 1'b0;
    endtask

    task automatic feed(input string tag, input int n, input bit bursty);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n && cyc < 500) begin
            in_valid = bursty ? (cyc % 3 != 1) : 1'b1;
            in_a = va[idx];
            in_b = vb[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) t_acc = $time;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check_val({tag, "_accepted"}, 32'(idx), 32'(n));
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        int base = rv_cnt;
        while (rv_cnt == base && n < 400) begin
            tick(1);
            n++;
        end
        check_val({tag, "_res_valid_seen"}, 32'(rv_cnt != base), 32'd1);
        tick(3);
    endtask

    int n;

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        clear_mon();

        // Reset state
        tick(3);
        check_val("rst_state", 32'(dbg_state), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_res", 32'(res), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_mac_go", 32'(mac_go), 32'd0);
        check_val("rst_mac_ab", {12'd0, mac_a, mac_b}, 32'd0);
        check_val("rst_mac_c", 32'(mac_c), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick(2);

        // 1: basic dot product, Lmac=2
        clear_mon();
        lmac = 2;
        va[0] = 10'd1; va[1] = 10'd2; va[2] = 10'd3; va[3] = 10'd4;
        vb[0] = 10'd5; vb[1] = 10'd6; vb[2] = 10'd7; vb[3] = 10'd8;
        do_start(4);
        check_val("t1_in_ready_issue", 32'(in_ready), 32'd1);
        check_val("t1_mac_c_start", 32'(mac_c), 32'd0);
        feed("t1", 4, 1'b0);
        wait_res("t1");
        check_val("t1_res", 32'(res), 32'(EXP1));
        check_val("t1_rv_count", 32'(rv_cnt), 32'd1);
        check_val("t1_go_count", 32'(go_cnt), 32'd4);
        check_val("t1_latency", 32'((t_rv - t_acc) / 10), 32'(lmac + 2));
        check_val("t1_busy_after", 32'(busy), 32'd0);
        check_val("t1_mac_c_idle", 32'(mac_c), 32'(EXP1));

        // 2: extreme operands, Lmac=3
        clear_mon();
        lmac = 3;
        va[0] = 10'h200; va[1] = 10'h200; va[2] = 10'h1FF;
        vb[0] = 10'h200; vb[1] = 10'h1FF; vb[2] = 10'h200;
        do_start(3);
        feed("t2", 3, 1'b0);
        wait_res("t2");
        check_val("t2_res", 32'(res), 32'(EXP2));
        check_val("t2_rv_count", 32'(rv_cnt), 32'd1);
        check_val("t2_go_count", 32'(go_cnt), 32'd3);

        // 3: zero-length vector
        clear_mon();
        do_start(0);
        check_val("t3_res_valid", 32'(res_valid), 32'd1);
        check_val("t3_res", 32'(res), 32'd0);
        tick(1);
        check_val("t3_res_valid_drop", 32'(res_valid), 32'd0);
        tick(2);
        check_val("t3_busy_seen", 32'(busy_seen), 32'd0);
        check_val("t3_rv_count", 32'(rv_cnt), 32'd1);

        // 4: MAC never answers -> timeout
        clear_mon();
        mac_drop = 1'b1;
        va[0] = 10'd5; vb[0] = 10'd5;
        do_start(2);
        feed("t4", 1, 1'b0);
        n = 1;
        while (!err && n < 200) begin
            tick(1);
            n++;
        end
        check_val("t4_err_cycle", 32'(n), 32'(TOUT + 1));
        check_val("t4_state_idle", 32'(dbg_state), 32'd0);
        check_val("t4_busy", 32'(busy), 32'd0);
        check_val("t4_mac_c_cleared", 32'(mac_c), 32'd0);
        tick(1);
        check_val("t4_err_pulse", 32'(err), 32'd0);
        check_val("t4_err_count", 32'(err_cnt), 32'd1);
        check_val("t4_rv_count", 32'(rv_cnt), 32'd0);
        mac_drop = 1'b0;

        // 5: bursty input plus enable low 5 cycles mid-WAIT
        clear_mon();
        lmac = 2;
        va[0] = 10'd1; va[1] = 10'd2; va[2] = 10'd3; va[3] = 10'd4;
        vb[0] = 10'd5; vb[1] = 10'd6; vb[2] = 10'd7; vb[3] = 10'd8;
        do_start(4);
        fork
            feed("t5", 4, 1'b1);
            begin
                int k = 0;
                while (go_cnt < 2 && k < 200) begin
                    tick(1);
                    k++;
                end
                enable = 1'b0;
                tick(5);
                enable = 1'b1;
            end
        join
        wait_res("t5");
        check_val("t5_res", 32'(res), 32'(EXP1));
        check_val("t5_rv_count", 32'(rv_cnt), 32'd1);
        check_val("t5_go_count", 32'(go_cnt), 32'd4);
        check_val("t5_go_width", 32'(go_run_viol), 32'd0);
        check_val("t5_rv_width", 32'(rv_run_viol), 32'd0);

        // 6: reset during WAIT of element 2, then a fresh job
        clear_mon();
        lmac = 3;
        do_start(4);
        feed("t6a", 2, 1'b0);
        check_val("t6_in_wait", 32'(dbg_state), 32'd2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        check_val("t6_idle_after_rst", 32'(dbg_state), 32'd0);
        check_val("t6_res_cleared", 32'(res), 32'd0);
        check_val("t6_stale_rv", 32'(rv_cnt), 32'd0);
        va[0] = 10'd3; va[1] = 10'd3;
        vb[0] = 10'd4; vb[1] = 10'd4;
        do_start(2);
        feed("t6b", 2, 1'b0);
        wait_res("t6");
        check_val("t6_res", 32'(res), 32'(EXP6));
        check_val("t6_rv_count", 32'(rv_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
